border_collision_multi: RTL and testbench
=========================================

Name: border_collision_multi

Overview:
- Multi-ball successor to the single-ball border collision block.
- Sits between the ball movers and the table border drawing logic.
- For each of NUM_BALLS channels it detects contact between that ball and the table borders. On contact it reflects the ball's velocity on the axes that hit a border, applying optional damping.
- Each contact produces exactly one event, guarded by a per-channel state machine with a frame-based cooldown. A saturating total hit counter is maintained.

Parameters:
- NUM_BALLS, 4, number of independent ball channels.
- POS_W, 11, position width (unsigned).
- VEL_W, 11, velocity width (signed, two's complement).
- BALL_DIAMETER, 32, ball size in pixels.
- TOP_OFFSET, 32, top border inner edge (Y).
- DOWN_OFFSET, 448, bottom border inner edge (Y).
- LEFT_OFFSET, 32, left border inner edge (X).
- RIGHT_OFFSET, 608, right border inner edge (X).
- DAMP_SHIFT, 0, damping shift. 0 = lossless reflection; k>0 = reflected magnitude is |v| - (|v| >> k).
- COOLDOWN_FRAMES, 2, number of startOfFrame pulses without contact required before a channel re-arms.
- CNT_W, 16, hit counter width.

Ports:
- clk, input, 1, system clock.
- resetN, input, 1, asynchronous active-low reset.
- startOfFrame, input, 1, one-cycle pulse at the start of each video frame.
- ballDR, input, NUM_BALLS, per-ball drawing request; bit i belongs to ball i.
- bordersDR, input, 1, border drawing request.
- ballPosX, input, NUM_BALLS*POS_W, packed top-left X positions; ball i occupies bits [i*POS_W +: POS_W].
- ballPosY, input, NUM_BALLS*POS_W, packed top-left Y positions, same packing.
- ballVelX, input, NUM_BALLS*VEL_W, packed signed X velocities.
- ballVelY, input, NUM_BALLS*VEL_W, packed signed Y velocities.
- ballVelXOut, output, NUM_BALLS*VEL_W, registered X velocity per ball.
- ballVelYOut, output, NUM_BALLS*VEL_W, registered Y velocity per ball.
- collisionOccurred, output, NUM_BALLS, one-cycle pulse per ball on a hit.
- hitCount, output, CNT_W, saturating total of hits across all balls.
- clearCount, input, 1, synchronous clear of hitCount.

Behaviour:
- Reset (async, resetN=0):
  - all ballVelXOut and ballVelYOut = 0.
  - collisionOccurred = 0.
  - hitCount = 0.
  - every channel state = ARMED, cooldown counter = 0.
- Latency and default output:
  - Outputs are registered with 1-cycle latency.
  - Default each cycle: ballVelXOut[i] <= ballVelX[i], ballVelYOut[i] <= ballVelY[i], collisionOccurred[i] <= 0.
- Contact: contact[i] = ballDR[i] & bordersDR.
- Per-channel FSM:
  - ARMED:
    - if contact[i], take a hit: pulse collisionOccurred[i], apply reflection, go to LATCHED.
    - otherwise stay in ARMED.
  - LATCHED:
    - stay while contact[i] persists; no further hits.
    - when contact[i] = 0, go to COOLDOWN and load the cooldown counter with COOLDOWN_FRAMES.
  - COOLDOWN:
    - on startOfFrame with contact[i] = 0, decrement the counter; go to ARMED when the counter reaches 0.
    - if contact[i] reasserts, go to LATCHED with no hit.
  - COOLDOWN_FRAMES = 0: LATCHED goes directly to ARMED.
- Reflection, evaluated in the hit cycle only:
  - X axis: reflect if (posX <= LEFT_OFFSET and velX < 0) or (posX + BALL_DIAMETER >= RIGHT_OFFSET and velX > 0).
  - Y axis: same rule with TOP_OFFSET and DOWN_OFFSET.
  - Both axes may reflect in the same cycle (corner hit).
  - The sum posX + BALL_DIAMETER is computed at POS_W+1 bits so it cannot wrap.
  - Reflected value = -sign(v) * (|v| - (|v| >> DAMP_SHIFT)).
  - |v| of the most negative value saturates to the maximum positive value.
  - A velocity of 0 never reflects.
  - A hit with no qualifying axis (for example, moving away from the border) still pulses collisionOccurred and velocities pass through unchanged.
- hitCount:
  - increments by popcount of the hits taken this cycle.
  - saturates at 2^CNT_W - 1.
  - clearCount has priority over any increment issued in the same cycle.
- Channels are fully independent; simultaneous hits on several balls in one cycle are all processed.
- Reset mid-cooldown or mid-contact returns all channels to ARMED.
- If contact is still present on the first cycle after reset, that is a fresh hit.

Test Plan:
1. Ball 0 at posX=20, velX=-5, ballDR[0]=bordersDR=1 for 10 cycles -> one collisionOccurred[0] pulse, 1 cycle later; velXOut=+5 for that cycle only; hitCount=1.
2. DAMP_SHIFT=2, ball 1 at posY=430 (430+32>=448), velY=+8 -> velYOut=-6. With velY=+1 -> -1.
3. Corner hit: ball 2 at (20,20), vel (-3,-4) -> out (+3,+4) with a single pulse.
4. COOLDOWN_FRAMES=2: contact ends, contact returns after 1 startOfFrame -> no pulse. Contact returns after 2 frames clear -> pulse.
5. Balls 0 and 3 hit in the same cycle -> both pulses asserted, hitCount += 2. With hitCount=0xFFFF -> stays at 0xFFFF. clearCount asserted in the same cycle -> 0.
6. Assert resetN=0 while in LATCHED with contact held, then release -> all outputs 0 during reset; a new hit pulse on the first active cycle.

Source files
------------

// File: rtl/border_collision_multi.sv
// Border contact detection for several independent balls: reflects velocity on contact,
// issues one hit event per contact and keeps a saturating total of hits.
module border_collision_multi #(
    parameter int NUM_BALLS       = 4,
    parameter int POS_W           = 11,
    parameter int VEL_W           = 11,
    parameter int BALL_DIAMETER   = 32,
    parameter int TOP_OFFSET      = 32,
    parameter int DOWN_OFFSET     = 448,
    parameter int LEFT_OFFSET     = 32,
    parameter int RIGHT_OFFSET    = 608,
    parameter int DAMP_SHIFT      = 0,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int CNT_W           = 16
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [NUM_BALLS-1:0]       ballDR,
    input  logic                       bordersDR,
    input  logic [NUM_BALLS*POS_W-1:0] ballPosX,
    input  logic [NUM_BALLS*POS_W-1:0] ballPosY,
    input  logic [NUM_BALLS*VEL_W-1:0] ballVelX,
    input  logic [NUM_BALLS*VEL_W-1:0] ballVelY,
    output logic [NUM_BALLS*VEL_W-1:0] ballVelXOut,
    output logic [NUM_BALLS*VEL_W-1:0] ballVelYOut,
    output logic [NUM_BALLS-1:0]       collisionOccurred,
    output logic [CNT_W-1:0]           hitCount,
    input  logic                       clearCount
);

    localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam int PC_W = $clog2(NUM_BALLS + 1);

    localparam logic [POS_W:0]   DIAM_E  = (POS_W+1)'(BALL_DIAMETER);
    localparam logic [POS_W:0]   TOP_E   = (POS_W+1)'(TOP_OFFSET);
    localparam logic [POS_W:0]   DOWN_E  = (POS_W+1)'(DOWN_OFFSET);
    localparam logic [POS_W:0]   LEFT_E  = (POS_W+1)'(LEFT_OFFSET);
    localparam logic [POS_W:0]   RIGHT_E = (POS_W+1)'(RIGHT_OFFSET);
    localparam logic [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};

    typedef enum logic [1:0] {ARMED, LATCHED, COOLDOWN} state_t;

    // Magnitude of the most negative velocity saturates so the reflection cannot overflow.
    function automatic logic [VEL_W-1:0] reflect(input logic signed [VEL_W-1:0] v);
        logic [VEL_W-1:0] mag;
        logic [VEL_W-1:0] kept;
        mag  = v[VEL_W-1] ? ((v == VEL_MIN) ? VEL_MAX : VEL_W'(-v)) : v;
        kept = (DAMP_SHIFT == 0) ? mag : mag - (mag >> DAMP_SHIFT);
        return v[VEL_W-1] ? kept : VEL_W'(-kept);
    endfunction

    logic [NUM_BALLS-1:0] hit;

    for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ch
        logic [POS_W:0]          px, py;
        logic signed [VEL_W-1:0] vx, vy;
        logic                    contact, ref_x, ref_y;
        state_t                  state;
        logic [CD_W-1:0]         cd_cnt;
        logic [VEL_W-1:0]        vx_q, vy_q;
        logic                    hit_q;

        assign px      = {1'b0, ballPosX[i*POS_W +: POS_W]};
        assign py      = {1'b0, ballPosY[i*POS_W +: POS_W]};
        assign vx      = ballVelX[i*VEL_W +: VEL_W];
        assign vy      = ballVelY[i*VEL_W +: VEL_W];
        assign contact = ballDR[i] & bordersDR;
        assign hit[i]  = contact && (state == ARMED);

        // Position sums are one bit wider than POS_W, so the far-edge test never wraps.
        assign ref_x = ((px <= LEFT_E) && vx[VEL_W-1]) ||
                       ((px + DIAM_E >= RIGHT_E) && !vx[VEL_W-1] && (vx != '0));
        assign ref_y = ((py <= TOP_E) && vy[VEL_W-1]) ||
                       ((py + DIAM_E >= DOWN_E) && !vy[VEL_W-1] && (vy != '0));

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                state  <= ARMED;
                cd_cnt <= '0;
                vx_q   <= '0;
                vy_q   <= '0;
                hit_q  <= 1'b0;
            end else begin
                vx_q  <= (hit[i] && ref_x) ? reflect(vx) : vx;
                vy_q  <= (hit[i] && ref_y) ? reflect(vy) : vy;
                hit_q <= hit[i];
                case (state)
                    ARMED: if (contact) state <= LATCHED;
                    LATCHED: begin
                        if (!contact) begin
                            if (COOLDOWN_FRAMES == 0) begin
                                state <= ARMED;
                            end else begin
                                state  <= COOLDOWN;
                                cd_cnt <= CD_W'(COOLDOWN_FRAMES);
                            end
                        end
                    end
                    COOLDOWN: begin
                        if (contact) begin
                            state <= LATCHED;
                        end else if (startOfFrame) begin
                            if (cd_cnt <= CD_W'(1)) begin
                                state  <= ARMED;
                                cd_cnt <= '0;
                            end else begin
                                cd_cnt <= cd_cnt - 1'b1;
                            end
                        end
                    end
                    default: state <= ARMED;
                endcase
            end
        end

        assign ballVelXOut[i*VEL_W +: VEL_W] = vx_q;
        assign ballVelYOut[i*VEL_W +: VEL_W] = vy_q;
        assign collisionOccurred[i]          = hit_q;
    end

    logic [PC_W-1:0] hits_now;
    logic [CNT_W:0]  cnt_sum;

    // NOTE: the accumulator is given a value before the loop so no latch is inferred.
    always_comb begin
        hits_now = '0;
        for (int i = 0; i < NUM_BALLS; i++) hits_now = hits_now + PC_W'(hit[i]);
    end

    assign cnt_sum = {1'b0, hitCount} + (CNT_W+1)'(hits_now);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)               hitCount <= '0;
        else if (clearCount)       hitCount <= '0;
        else if (cnt_sum[CNT_W])   hitCount <= '1;
        else                       hitCount <= cnt_sum[CNT_W-1:0];
    end

endmodule

// File: tb/tb_border_collision_multi.sv
// Bench for border_collision_multi: two instances (lossless / damped, short counter) driven
// by directed scenarios and random traffic, checked against a frame-level behavioural model.
module tb_border_collision_multi;

    localparam int NB = 4;
    localparam int PW = 11;
    localparam int VW = 11;

    logic clk = 1'b0, resetN = 1'b0, sof = 1'b0, borders_dr = 1'b0, clear_cnt = 1'b0;
    logic [NB-1:0]    ball_dr = '0;
    logic [NB*PW-1:0] pos_x = '0, pos_y = '0;
    logic [NB*VW-1:0] vel_x = '0, vel_y = '0;

    logic [NB*VW-1:0] a_vx, a_vy, b_vx, b_vy;
    logic [NB-1:0]    a_coll, b_coll;
    logic [15:0]      a_cnt;
    logic [3:0]       b_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    border_collision_multi dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .ballDR(ball_dr), .bordersDR(borders_dr),
        .ballPosX(pos_x), .ballPosY(pos_y), .ballVelX(vel_x), .ballVelY(vel_y),
        .ballVelXOut(a_vx), .ballVelYOut(a_vy), .collisionOccurred(a_coll),
        .hitCount(a_cnt), .clearCount(clear_cnt)
    );

    border_collision_multi #(.DAMP_SHIFT(2), .COOLDOWN_FRAMES(0), .CNT_W(4)) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .ballDR(ball_dr), .bordersDR(borders_dr),
        .ballPosX(pos_x), .ballPosY(pos_y), .ballVelX(vel_x), .ballVelY(vel_y),
        .ballVelXOut(b_vx), .ballVelYOut(b_vy), .collisionOccurred(b_coll),
        .hitCount(b_cnt), .clearCount(clear_cnt)
    );

    logic [107:0] act_a, exp_a;
    logic [95:0]  act_b, exp_b;
    assign act_a = {a_vx, a_vy, a_coll, a_cnt};
    assign act_b = {b_vx, b_vy, b_coll, b_cnt};

    // Reference model: a channel is "engaged" from a hit until contact has been absent
    // for the required number of frame starts (counted after the cycle contact ended).
    logic [NB*VW-1:0] exp_vx [2];
    logic [NB*VW-1:0] exp_vy [2];
    logic [NB-1:0]    exp_coll [2];
    int               mcnt [2];
    bit               engaged [2][NB];
    int               quiet [2][NB];
    bit               prev_c [2][NB];

    function automatic int reflect(input int v, input int pos, input int lo, input int hi,
                                   input int sh);
        int mag, m;
        if (v == 0) return 0;
        if (!((pos <= lo && v < 0) || (pos + 32 >= hi && v > 0))) return v;
        mag = (v < 0) ? -v : v;
        if (mag > 1023) mag = 1023;
        m = (sh == 0) ? mag : mag - (mag >> sh);
        return (v < 0) ? m : -m;
    endfunction

    task automatic pack_exp();
        exp_a = {exp_vx[0], exp_vy[0], exp_coll[0], 16'(mcnt[0])};
        exp_b = {exp_vx[1], exp_vy[1], exp_coll[1], 4'(mcnt[1])};
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_vx[d] = '0; exp_vy[d] = '0; exp_coll[d] = '0; mcnt[d] = 0;
            for (int i = 0; i < NB; i++) begin
                engaged[d][i] = 0; quiet[d][i] = 0; prev_c[d][i] = 0;
            end
        end
        pack_exp();
    endtask

    task automatic model_cycle();
        for (int d = 0; d < 2; d++) begin
            int cf, sh, mx, hits;
            cf = (d == 0) ? 2 : 0;
            sh = (d == 0) ? 0 : 2;
            mx = (d == 0) ? 65535 : 15;
            hits = 0;
            for (int i = 0; i < NB; i++) begin
                logic signed [VW-1:0] sx, sy;
                int px, py, vx, vy, rx, ry;
                bit c, h;
                sx = vel_x[i*VW +: VW]; sy = vel_y[i*VW +: VW];
                vx = int'(sx); vy = int'(sy);
                px = int'(pos_x[i*PW +: PW]); py = int'(pos_y[i*PW +: PW]);
                c = ball_dr[i] & borders_dr;
                h = 0;
                if (!engaged[d][i]) begin
                    if (c) begin h = 1; engaged[d][i] = 1; quiet[d][i] = 0; end
                end else if (c) begin
                    quiet[d][i] = 0;
                end else if (prev_c[d][i]) begin
                    quiet[d][i] = 0;
                    if (cf == 0) engaged[d][i] = 0;
                end else if (sof) begin
                    quiet[d][i]++;
                    if (quiet[d][i] >= cf) engaged[d][i] = 0;
                end
                prev_c[d][i] = c;
                rx = h ? reflect(vx, px, 32, 608, sh) : vx;
                ry = h ? reflect(vy, py, 32, 448, sh) : vy;
                exp_vx[d][i*VW +: VW] = rx[VW-1:0];
                exp_vy[d][i*VW +: VW] = ry[VW-1:0];
                exp_coll[d][i] = h;
                hits += int'(h);
            end
            mcnt[d] = clear_cnt ? 0 : ((mcnt[d] + hits > mx) ? mx : mcnt[d] + hits);
        end
        pack_exp();
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ball(input int i, input int px, input int py, input int vx, input int vy);
        pos_x[i*PW +: PW] = PW'(px);
        pos_y[i*PW +: PW] = PW'(py);
        vel_x[i*VW +: VW] = VW'(vx);
        vel_y[i*VW +: VW] = VW'(vy);
    endtask

    task automatic do_reset();
        resetN = 1'b0; ball_dr = '0; borders_dr = 1'b0; sof = 1'b0; clear_cnt = 1'b0;
        for (int i = 0; i < NB; i++) set_ball(i, 300, 200, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        ball_dr = '1; borders_dr = 1'b1;
        for (int i = 0; i < NB; i++) set_ball(i, 10, 10, -7, -7);
        resetN = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        tests++;
        if (act_a !== exp_a || act_b !== exp_b) begin
            fails++;
            $display("FAIL reset: a=%h b=%h, required all zero", act_a, act_b);
        end
        do_reset();
    endtask

    task automatic test_single_hit();
        do_reset();
        set_ball(0, 20, 200, -5, 3);
        ball_dr = 4'b0001; borders_dr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            tests++;
            if (act_a !== exp_a || act_b !== exp_b) begin
                fails++;
                $display("FAIL single_hit cyc %0d: a=%h exp %h b=%h exp %h", k, act_a, exp_a, act_b, exp_b);
            end
            tests++;
            if (k == 0 && (a_coll !== 4'b0001 || a_vx[0 +: VW] !== VW'(5))) begin
                fails++;
                $display("FAIL single_hit first: coll=%b vx=%0d, required 0001 and 5", a_coll, a_vx[0 +: VW]);
            end else if (k > 0 && (a_coll !== 4'b0000 || a_vx[0 +: VW] !== VW'(-5))) begin
                fails++;
                $display("FAIL single_hit held cyc %0d: coll=%b vx=%h, required 0000 and -5", k, a_coll, a_vx[0 +: VW]);
            end
        end
        tests++;
        if (a_cnt !== 16'd1) begin
            fails++;
            $display("FAIL single_hit count: %0d, required 1", a_cnt);
        end
    endtask

    task automatic test_damping();
        do_reset();
        set_ball(1, 300, 430, 0, 8);
        ball_dr = 4'b0010; borders_dr = 1'b1;
        step();
        tests++;
        if (b_vy[VW +: VW] !== VW'(-6) || a_vy[VW +: VW] !== VW'(-8) || act_b !== exp_b) begin
            fails++;
            $display("FAIL damping v8: b_vy=%h a_vy=%h, required -6 and -8", b_vy[VW +: VW], a_vy[VW +: VW]);
        end
        ball_dr = '0;
        step();
        set_ball(1, 300, 430, 0, 1);
        ball_dr = 4'b0010;
        step();
        tests++;
        if (b_vy[VW +: VW] !== VW'(-1) || act_a !== exp_a || act_b !== exp_b) begin
            fails++;
            $display("FAIL damping v1: b_vy=%h, required -1 (a=%h exp %h)", b_vy[VW +: VW], act_a, exp_a);
        end
    endtask

    task automatic test_corner();
        do_reset();
        set_ball(2, 20, 20, -3, -4);
        ball_dr = 4'b0100; borders_dr = 1'b1;
        step();
        tests++;
        if (a_vx[2*VW +: VW] !== VW'(3) || a_vy[2*VW +: VW] !== VW'(4) || a_coll !== 4'b0100) begin
            fails++;
            $display("FAIL corner: vx=%h vy=%h coll=%b, required 3 4 0100",
                     a_vx[2*VW +: VW], a_vy[2*VW +: VW], a_coll);
        end
        step();
        tests++;
        if (a_coll !== 4'b0000 || act_b !== exp_b) begin
            fails++;
            $display("FAIL corner second pulse: coll=%b, required 0000", a_coll);
        end
    endtask

    task automatic test_cooldown();
        int code [10];
        code = '{1, 0, 2, 0, 1, 0, 2, 0, 2, 1};
        do_reset();
        set_ball(0, 300, 200, 2, 2);
        borders_dr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ball_dr = (code[k] == 1) ? 4'b0001 : 4'b0000;
            sof     = (code[k] == 2);
            step();
            tests++;
            if (act_a !== exp_a || act_b !== exp_b) begin
                fails++;
                $display("FAIL cooldown cyc %0d: a=%h exp %h b=%h exp %h", k, act_a, exp_a, act_b, exp_b);
            end
        end
        sof = 1'b0;
        tests++;
        if (a_coll !== 4'b0001 || a_cnt !== 16'd2) begin
            fails++;
            $display("FAIL cooldown rearm: coll=%b cnt=%0d, required 0001 and 2", a_coll, a_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ball_dr = 4'b1001; borders_dr = 1'b1;
        step();
        tests++;
        if (a_coll !== 4'b1001 || a_cnt !== 16'd2 || b_cnt !== 4'd2) begin
            fails++;
            $display("FAIL simultaneous: coll=%b cnt=%0d/%0d, required 1001 and 2", a_coll, a_cnt, b_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            ball_dr = (k % 2 == 0) ? 4'b1111 : 4'b0000;
            step();
            tests++;
            if (act_a !== exp_a || act_b !== exp_b) begin
                fails++;
                $display("FAIL saturate cyc %0d: a=%h exp %h b=%h exp %h", k, act_a, exp_a, act_b, exp_b);
            end
        end
        tests++;
        if (b_cnt !== 4'hF) begin
            fails++;
            $display("FAIL saturate: cnt=%0d, required 15", b_cnt);
        end
        ball_dr = 4'b1111; clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        tests++;
        if (b_cnt !== 4'd0 || a_cnt !== 16'd0 || b_coll !== 4'b1111) begin
            fails++;
            $display("FAIL clear priority: cnt=%0d/%0d coll=%b, required 0 0 1111", a_cnt, b_cnt, b_coll);
        end
    endtask

    task automatic test_reset_mid_contact();
        do_reset();
        set_ball(0, 20, 200, -5, 0);
        ball_dr = 4'b0001; borders_dr = 1'b1;
        step();
        step();
        #2;
        resetN = 1'b0;
        model_reset();
        #1;
        tests++;
        if (act_a !== exp_a || act_b !== exp_b) begin
            fails++;
            $display("FAIL async reset: a=%h b=%h, required zero", act_a, act_b);
        end
        @(posedge clk);
        #1;
        resetN = 1'b1;
        step();
        tests++;
        if (a_coll !== 4'b0001 || a_vx[0 +: VW] !== VW'(5) || act_b !== exp_b) begin
            fails++;
            $display("FAIL post-reset hit: coll=%b vx=%h, required 0001 and 5", a_coll, a_vx[0 +: VW]);
        end
    endtask

    function automatic int rand_pos(input int lo, input int hi);
        case ($urandom_range(0, 2))
            0:       return int'($urandom_range(0, lo + 8));
            1:       return int'($urandom_range(hi - 40, hi));
            default: return int'($urandom_range(0, 2047));
        endcase
    endfunction

    function automatic int rand_vel();
        case ($urandom_range(0, 7))
            0:       return -1024;
            1:       return 0;
            default: return int'($urandom_range(0, 2047)) - 1024;
        endcase
    endfunction

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NB; i++)
                set_ball(i, rand_pos(32, 608), rand_pos(32, 448), rand_vel(), rand_vel());
            ball_dr    = NB'($urandom);
            borders_dr = ($urandom_range(0, 9) < 7);
            sof        = ($urandom_range(0, 4) == 0);
            clear_cnt  = ($urandom_range(0, 29) == 0);
            step();
            tests++;
            if (act_a !== exp_a || act_b !== exp_b) begin
                fails++;
                if (bad < 5)
                    $display("FAIL random cyc %0d: a=%h exp %h b=%h exp %h", k, act_a, exp_a, act_b, exp_b);
                bad++;
            end
        end
        sof = 1'b0; clear_cnt = 1'b0;
    endtask

    initial begin
        #12;
        test_reset();
        test_single_hit();
        test_damping();
        test_corner();
        test_cooldown();
        test_back_to_back();
        test_reset_mid_contact();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
